dm_access_arbiter: RTL and testbench
====================================

// Module: dm_access_arbiter
// PURPOSE
//  Shares the single-port data memory between the SPI slave FSM (requester 0) and a local host/loader port (requester 1).
//  Each requester uses a req/ack handshake; the arbiter picks one, sequences the memory access and returns read data.
//  Sits between the SPI slave FSM/shift-register datapath and the data memory, all on the peripheral clock.
// PARAMETERS
//  ADDR_WIDTH    7  data memory address width
//  DATA_WIDTH    8  data memory word width
//  SPI_PRIORITY  0  0 = round-robin between requesters; 1 = SPI wins ties, subject to MAX_SPI_RUN
//  MAX_SPI_RUN   4  SPI_PRIORITY=1 only: max consecutive SPI grants while host waits; then host is forced once
// PORTS
//  clk            in   1   peripheral clock, all logic on posedge
//  resetN         in   1   asynchronous, active-low reset
//  spiReq         in   1   SPI request; hold with addr/data stable until spiAck
//  spiWrite       in   1   1 = write, 0 = read
//  spiAddr        in   AW  SPI address
//  spiWData       in   DW  SPI write data
//  spiAck         out  1   one-cycle pulse: transaction complete
//  spiRData       out  DW  read data, valid in the spiAck cycle, held until the next SPI read ack
//  hostReq/hostWrite/hostAddr/hostWData/hostAck/hostRData: same as spi*, for the host
//  dmAddr         out  AW  memory address
//  dmWData        out  DW  memory write data
//  dmWriteEnable  out  1   memory write strobe, one cycle
//  dmRData        in   DW  memory read data, synchronous, valid the cycle after dmAddr is presented
//  busy           out  1   high from grant to ack inclusive
//  owner          out  1   0 = SPI, 1 = host; valid while busy
// BEHAVIOUR
//  - Reset (resetN low, async): all outputs 0; state IDLE; lastOwner=host, so SPI wins the first tie; spiRunCount=0.
//  - All outputs are registered.
//  - FSM states: IDLE, ISSUE, CAPTURE, ACK.
//    IDLE -> ISSUE: any req sampled high. Latch owner, addr, wdata and write flag. Set busy.
//    ISSUE: drive dmAddr and dmWData; dmWriteEnable = write flag. Next state: write -> ACK; read -> CAPTURE.
//    CAPTURE: latch dmRData into the owner's rData. Next state: ACK.
//    ACK: pulse the owner's ack; clear busy; update lastOwner and spiRunCount. Next state: IDLE.
//  - Latency from req first sampled in cycle N:
//    write: dmWriteEnable in N+1, ack in N+2.
//    read: dmAddr in N+1, capture in N+2, ack and rData in N+3.
//  - Throughput: one transaction per 3 (write) or 4 (read) cycles. Req still high in the cycle after ack = new request.
//  - Arbitration, sampled in IDLE only:
//    SPI_PRIORITY=0: on a tie, grant the requester that is not lastOwner.
//    SPI_PRIORITY=1: on a tie, grant SPI unless spiRunCount==MAX_SPI_RUN, then grant host.
//  - spiRunCount: +1 on each SPI ack while hostReq high; cleared on a host ack or when hostReq low at SPI ack; saturates.
//  - Only the owner's inputs are sampled, and only at IDLE->ISSUE. Later input changes do not affect that transaction.
//  - Req dropped after grant: the transaction still completes and ack still pulses. Memory writes are never abandoned.
//  - Req dropped while waiting (never granted): not served, no ack.
//  - Non-owner ack, rData and any dm* side effects are untouched during a transaction.
//  - dmAddr and dmWData hold their last value outside ISSUE; dmWriteEnable is high only in ISSUE of a write.
//  - Reset mid-transaction aborts at once: dmWriteEnable and acks drop asynchronously; no partial ack after release.
// STRUCTURE
//  - Package dm_arb_pkg: state encoding (IDLE/ISSUE/CAPTURE/ACK), OWNER_SPI=0, OWNER_HOST=1, default widths.
//  - Sub-module dm_arb_pick: two-way picker. Inputs: reqs, lastOwner, spiRunCount, params. Output: winner. Combinational; the FSM stays in the top.
// TESTING
//  1 Reset: resetN=0 mid-write -> all outputs 0 immediately; after release, state IDLE with no ack.
//  2 SPI write 0x55 to addr 0x12 in cycle N -> dmWriteEnable=1, dmAddr=0x12 in N+1; spiAck in N+2; memory[0x12]=0x55.
//  3 Host read of addr 0x12 -> hostAck in N+3 with hostRData=0x55; spiAck stays 0.
//  4 Round-robin: both reqs held high for 4 transactions -> owners SPI, host, SPI, host.
//  5 SPI_PRIORITY=1, MAX_SPI_RUN=4, both held high -> 4 SPI acks, then 1 host ack, then SPI again.
//  6 Req dropped: spiReq drops in ISSUE of a write -> write still occurs and spiAck pulses. A waiting hostReq dropped before grant -> no hostAck.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the data-memory access arbiter.
// Owner encoding doubles as the requester index.
package dm_arb_pkg;

  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  localparam logic OWNER_SPI  = 1'b0;
  localparam logic OWNER_HOST = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_ACK
  } state_e;

  function automatic int run_w(input int max_run);
    return (max_run < 1) ? 1 : $clog2(max_run + 1);
  endfunction

endpackage

// File: rtl/dm_arb_pick.sv
// Two-way requester picker for the data-memory arbiter.
// Purely combinational; sampled by the top only in IDLE.
module dm_arb_pick
  import dm_arb_pkg::*;
#(
  parameter int SPI_PRIORITY = 0,
  parameter int MAX_SPI_RUN  = 4,
  parameter int RW           = run_w(MAX_SPI_RUN)
) (
  input  logic          spi_req_i,
  input  logic          host_req_i,
  input  logic          last_owner_i,
  input  logic [RW-1:0] run_cnt_i,
  output logic          winner_o
);

  logic tie_win;

  always_comb begin
    if (SPI_PRIORITY != 0) begin
      tie_win = (run_cnt_i == RW'(MAX_SPI_RUN)) ? OWNER_HOST
                                                : OWNER_SPI;
    end else begin
      tie_win = (last_owner_i == OWNER_SPI) ? OWNER_HOST
                                            : OWNER_SPI;
    end
  end

  always_comb begin
    winner_o = OWNER_SPI;
    unique case (1'b1)
      (spi_req_i & ~host_req_i): winner_o = OWNER_SPI;
      (host_req_i & ~spi_req_i): winner_o = OWNER_HOST;
      default:                   winner_o = tie_win;
    endcase
  end

endmodule

// File: rtl/dm_access_arbiter.sv
// Shares the single-port data memory between the SPI slave
// and the host/loader port with a req/ack handshake.
module dm_access_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_W,
  parameter int DATA_WIDTH   = DATA_W,
  parameter int SPI_PRIORITY = 0,
  parameter int MAX_SPI_RUN  = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  spiReq,
  input  logic                  spiWrite,
  input  logic [ADDR_WIDTH-1:0] spiAddr,
  input  logic [DATA_WIDTH-1:0] spiWData,
  output logic                  spiAck,
  output logic [DATA_WIDTH-1:0] spiRData,
  input  logic                  hostReq,
  input  logic                  hostWrite,
  input  logic [ADDR_WIDTH-1:0] hostAddr,
  input  logic [DATA_WIDTH-1:0] hostWData,
  output logic                  hostAck,
  output logic [DATA_WIDTH-1:0] hostRData,
  output logic [ADDR_WIDTH-1:0] dmAddr,
  output logic [DATA_WIDTH-1:0] dmWData,
  output logic                  dmWriteEnable,
  input  logic [DATA_WIDTH-1:0] dmRData,
  output logic                  busy,
  output logic                  owner
);

  localparam int RW = run_w(MAX_SPI_RUN);

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  wr_q, wr_d;
  logic                  busy_q, busy_d;
  logic                  last_q, last_d;
  logic [RW-1:0]         run_q, run_d;
  logic                  spi_ack_q, spi_ack_d;
  logic                  host_ack_q, host_ack_d;
  logic [DATA_WIDTH-1:0] spi_rd_q, spi_rd_d;
  logic [DATA_WIDTH-1:0] host_rd_q, host_rd_d;
  logic [ADDR_WIDTH-1:0] dm_addr_q, dm_addr_d;
  logic [DATA_WIDTH-1:0] dm_wdata_q, dm_wdata_d;
  logic                  dm_we_q, dm_we_d;
  logic                  winner;

  dm_arb_pick #(
    .SPI_PRIORITY (SPI_PRIORITY),
    .MAX_SPI_RUN  (MAX_SPI_RUN),
    .RW           (RW)
  ) u_pick (
    .spi_req_i    (spiReq),
    .host_req_i   (hostReq),
    .last_owner_i (last_q),
    .run_cnt_i    (run_q),
    .winner_o     (winner)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wr_d       = wr_q;
    busy_d     = busy_q;
    last_d     = last_q;
    run_d      = run_q;
    spi_ack_d  = 1'b0;
    host_ack_d = 1'b0;
    spi_rd_d   = spi_rd_q;
    host_rd_d  = host_rd_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    dm_we_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // Memory outputs load on the grant edge so they appear in ISSUE
        if (spiReq || hostReq) begin
          state_d = S_ISSUE;
          owner_d = winner;
          busy_d  = 1'b1;
          if (winner == OWNER_HOST) begin
            wr_d       = hostWrite;
            dm_addr_d  = hostAddr;
            dm_wdata_d = hostWData;
          end else begin
            wr_d       = spiWrite;
            dm_addr_d  = spiAddr;
            dm_wdata_d = spiWData;
          end
          dm_we_d = wr_d;
        end
      end
      S_ISSUE: begin
        if (wr_q) begin
          state_d    = S_ACK;
          spi_ack_d  = (owner_q == OWNER_SPI);
          host_ack_d = (owner_q == OWNER_HOST);
        end else begin
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        state_d    = S_ACK;
        spi_ack_d  = (owner_q == OWNER_SPI);
        host_ack_d = (owner_q == OWNER_HOST);
        if (owner_q == OWNER_HOST) host_rd_d = dmRData;
        else                       spi_rd_d  = dmRData;
      end
      S_ACK: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        last_d  = owner_q;
        if (owner_q == OWNER_SPI && hostReq) begin
          if (run_q != RW'(MAX_SPI_RUN)) run_d = run_q + 1'b1;
        end else begin
          run_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      owner_q    <= OWNER_SPI;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      last_q     <= OWNER_HOST;
      run_q      <= '0;
      spi_ack_q  <= 1'b0;
      host_ack_q <= 1'b0;
      spi_rd_q   <= '0;
      host_rd_q  <= '0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_we_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wr_q       <= wr_d;
      busy_q     <= busy_d;
      last_q     <= last_d;
      run_q      <= run_d;
      spi_ack_q  <= spi_ack_d;
      host_ack_q <= host_ack_d;
      spi_rd_q   <= spi_rd_d;
      host_rd_q  <= host_rd_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      dm_we_q    <= dm_we_d;
    end
  end

  assign spiAck        = spi_ack_q;
  assign hostAck       = host_ack_q;
  assign spiRData      = spi_rd_q;
  assign hostRData     = host_rd_q;
  assign dmAddr        = dm_addr_q;
  assign dmWData       = dm_wdata_q;
  assign dmWriteEnable = dm_we_q;
  assign busy          = busy_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_dm_access_arbiter.sv
// Bench for dm_access_arbiter: a round-robin and an SPI-priority
// instance share stimulus, each with its own synchronous RAM.
module tb_dm_access_arbiter;
  import dm_arb_pkg::*;

  localparam int AW   = 7;
  localparam int DW   = 8;
  localparam int MAXR = 4;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic spiReq = 1'b0, spiWrite = 1'b0;
  logic hostReq = 1'b0, hostWrite = 1'b0;
  logic [AW-1:0] spiAddr = '0, hostAddr = '0;
  logic [DW-1:0] spiWData = '0, hostWData = '0;

  logic          spiAck[2], hostAck[2], dmWe[2];
  logic          busy[2], owner[2];
  logic [DW-1:0] spiRData[2], hostRData[2];
  logic [DW-1:0] dmWData[2], dmRData[2];
  logic [AW-1:0] dmAddr[2];
  logic [DW-1:0] ram[2][128];

  logic [DW-1:0] ref_mem[128];
  logic [AW-1:0] written[$];
  logic          last_m[2];
  int            run_m[2];
  logic [15:0]   seq[2];
  int            nack[2];
  int            total = 0;
  int            passes = 0;
  int            fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (dmWe[k[0]]) ram[k[0]][dmAddr[k[0]]] <= dmWData[k[0]];
      dmRData[k[0]] <= ram[k[0]][dmAddr[k[0]]];
    end
  end

  dm_access_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SPI_PRIORITY(0), .MAX_SPI_RUN(MAXR)
  ) u_rr (
    .clk(clk), .resetN(resetN),
    .spiReq(spiReq), .spiWrite(spiWrite),
    .spiAddr(spiAddr), .spiWData(spiWData),
    .spiAck(spiAck[0]), .spiRData(spiRData[0]),
    .hostReq(hostReq), .hostWrite(hostWrite),
    .hostAddr(hostAddr), .hostWData(hostWData),
    .hostAck(hostAck[0]), .hostRData(hostRData[0]),
    .dmAddr(dmAddr[0]), .dmWData(dmWData[0]),
    .dmWriteEnable(dmWe[0]), .dmRData(dmRData[0]),
    .busy(busy[0]), .owner(owner[0])
  );

  dm_access_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .SPI_PRIORITY(1), .MAX_SPI_RUN(MAXR)
  ) u_pr (
    .clk(clk), .resetN(resetN),
    .spiReq(spiReq), .spiWrite(spiWrite),
    .spiAddr(spiAddr), .spiWData(spiWData),
    .spiAck(spiAck[1]), .spiRData(spiRData[1]),
    .hostReq(hostReq), .hostWrite(hostWrite),
    .hostAddr(hostAddr), .hostWData(hostWData),
    .hostAck(hostAck[1]), .hostRData(hostRData[1]),
    .dmAddr(dmAddr[1]), .dmWData(dmWData[1]),
    .dmWriteEnable(dmWe[1]), .dmRData(dmRData[1]),
    .busy(busy[1]), .owner(owner[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Who wins when both requesters are waiting (k=0 round-robin, k=1 SPI-priority)
  function automatic logic tie_winner(input int k);
    if (k == 0) return (last_m[0] == OWNER_SPI) ? OWNER_HOST : OWNER_SPI;
    return (run_m[1] >= MAXR) ? OWNER_HOST : OWNER_SPI;
  endfunction

  task automatic note_ack(input int k, input logic who, input logic host_hi);
    last_m[k[0]] = who;
    if (who == OWNER_SPI && host_hi)
      run_m[k[0]] = (run_m[k[0]] < MAXR) ? run_m[k[0]] + 1 : MAXR;
    else
      run_m[k[0]] = 0;
  endtask

  // One transaction from a lone requester, started in an IDLE cycle
  task automatic do_single(input logic who, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic drop);
    logic [1:0] exp_ack;
    exp_ack = (who == OWNER_HOST) ? 2'b10 : 2'b01;
    if (who == OWNER_HOST) begin
      hostReq = 1; hostWrite = wr; hostAddr = a; hostWData = d;
    end else begin
      spiReq = 1; spiWrite = wr; spiAddr = a; spiWData = d;
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("issue_we", dmWe[k[0]], wr);
      chk("issue_addr", dmAddr[k[0]], a);
      chk("issue_busy_own", {busy[k[0]], owner[k[0]]}, {1'b1, who});
      if (wr) chk("issue_wdata", dmWData[k[0]], d);
    end
    spiAddr = AW'($urandom); spiWData = DW'($urandom);
    hostAddr = AW'($urandom); hostWData = DW'($urandom);
    spiWrite = ~spiWrite; hostWrite = ~hostWrite;
    if (drop) begin spiReq = 0; hostReq = 0; end
    if (!wr) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        chk("read_wait", {hostAck[k[0]], spiAck[k[0]]}, 2'b00);
    end
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("ack", {hostAck[k[0]], spiAck[k[0]]}, exp_ack);
      if (!wr)
        chk("rdata", (who == OWNER_HOST) ? hostRData[k[0]] : spiRData[k[0]],
            ref_mem[a]);
    end
    spiReq = 0; hostReq = 0;
    for (int k = 0; k < 2; k++) note_ack(k, who, hostReq);
    if (wr) begin ref_mem[a] = d; written.push_back(a); end
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("idle_busy", busy[k[0]], 1'b0);
  endtask

  initial begin
    logic seen;
    logic wr;
    logic [AW-1:0] a;
    for (int k = 0; k < 2; k++) begin
      last_m[k[0]] = OWNER_HOST; run_m[k[0]] = 0;
      seq[k[0]] = '0; nack[k[0]] = 0;
    end

    #3;
    for (int k = 0; k < 2; k++) begin
      chk("reset_ctl", {dmWe[k[0]], spiAck[k[0]], hostAck[k[0]],
                        busy[k[0]], owner[k[0]]}, 0);
      chk("reset_dm", {dmAddr[k[0]], dmWData[k[0]]}, 0);
      chk("reset_rd", {spiRData[k[0]], hostRData[k[0]]}, 0);
    end
    repeat (2) @(negedge clk);
    resetN = 1;
    @(negedge clk);

    do_single(OWNER_SPI, 1'b1, 7'h12, 8'h55, 1'b0);
    chk("mem_12", ram[0][7'h12], 8'h55);
    do_single(OWNER_HOST, 1'b0, 7'h12, 8'h00, 1'b0);
    do_single(OWNER_SPI, 1'b1, 7'h13, DW'($urandom), 1'b1);
    chk("mem_13_after_drop", ram[0][7'h13], ref_mem[7'h13]);

    // Host raises and drops its request while SPI owns the memory
    spiReq = 1; spiWrite = 1; spiAddr = 7'h30; spiWData = 8'h3C;
    @(negedge clk);
    hostReq = 1; hostWrite = 0; hostAddr = 7'h12;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("spi_ack_w_wait", spiAck[k[0]], 1'b1);
    hostReq = 0; spiReq = 0;
    for (int k = 0; k < 2; k++) note_ack(k, OWNER_SPI, hostReq);
    ref_mem[7'h30] = 8'h3C; written.push_back(7'h30);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      seen |= hostAck[0] | hostAck[1] | busy[0] | busy[1];
    end
    chk("dropped_host_no_ack", seen, 1'b0);

    for (int i = 0; i < 16; i++) begin
      wr = 1'($urandom_range(0, 1));
      a = wr ? AW'($urandom)
             : written[$urandom_range(0, written.size() - 1)];
      do_single(1'($urandom_range(0, 1)), wr, a, DW'($urandom),
                ($urandom_range(0, 3) == 0));
    end

    // Reset in the ISSUE cycle of a write
    spiReq = 1; spiWrite = 1; spiAddr = 7'h40; spiWData = 8'hC3;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) chk("pre_rst_we", dmWe[k[0]], 1'b1);
    resetN = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_mid_ctl", {dmWe[k[0]], spiAck[k[0]], hostAck[k[0]],
                          busy[k[0]], owner[k[0]]}, 0);
      chk("rst_mid_dm", {dmAddr[k[0]], dmWData[k[0]]}, 0);
    end
    spiReq = 0;
    @(negedge clk);
    resetN = 1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        seen |= spiAck[k[0]] | hostAck[k[0]] | busy[k[0]] | dmWe[k[0]];
    end
    chk("post_rst_quiet", seen, 1'b0);
    for (int k = 0; k < 2; k++) begin
      last_m[k[0]] = OWNER_HOST; run_m[k[0]] = 0;
    end

    do_single(OWNER_HOST, 1'b1, 7'h21, DW'($urandom), 1'b0);

    // Both requesters held: SPI writes, host reads
    spiWrite = 1; spiAddr = 7'h20; spiWData = DW'($urandom);
    hostWrite = 0; hostAddr = 7'h21;
    spiReq = 1; hostReq = 1;
    for (int c = 0; c < 52; c++) begin
      @(negedge clk);
      if (c == 44) begin spiReq = 0; hostReq = 0; end
      for (int k = 0; k < 2; k++) begin
        chk("ack_excl", spiAck[k[0]] & hostAck[k[0]], 1'b0);
        if (spiAck[k[0]] | hostAck[k[0]]) begin
          chk((k == 0) ? "rr_owner" : "pr_owner", hostAck[k[0]],
              tie_winner(k));
          if (hostAck[k[0]])
            chk("held_rdata", hostRData[k[0]], ref_mem[7'h21]);
          if (nack[k[0]] < 16) seq[k[0]][nack[k[0]][3:0]] = hostAck[k[0]];
          nack[k[0]]++;
          note_ack(k, hostAck[k[0]], hostReq);
        end
      end
    end
    chk("rr_ack_count", nack[0] >= 4, 1'b1);
    chk("pr_ack_count", nack[1] >= 6, 1'b1);
    chk("rr_sequence", seq[0][3:0], 4'b1010);
    chk("pr_sequence", seq[1][5:0], 6'b010000);
    for (int k = 0; k < 2; k++) chk("end_idle", busy[k[0]], 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
